fp8_accumulator: RTL and testbench
==================================

Name: fp8_accumulator

Overview:
- Sequential stage directly downstream of the 8-bit FP multiplier.
- Consumes a stream of FP8 products over a valid/ready handshake and sums them into a running FP8 accumulator.
- When a beat flagged last has been added, presents the group sum on a valid/ready output and clears for the next group.
- Format, same as the multiplier output: bit7 sign, bits6:4 exponent (bias 3), bits3:0 fraction with implicit leading 1. Any byte with bits6:0 == 0 is zero.

Parameters:
- MAX_ALIGN, 5: exponent difference at or above which the smaller operand is discarded without alignment cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  high only in ACCEPT and rst low; transfer = in_valid & in_ready.
- in_data  input  8  FP8 addend (multiplier product).
- in_last  input  1  marks final addend of the group.
- out_valid  output  1  group sum available.
- out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
- out_data  output  8  FP8 group sum.
- out_overflow  output  1  group saturated; valid with out_valid.
- busy  output  1  high in any state other than ACCEPT.

Behaviour:
- Reset (async assert): state ACCEPT, accumulator 0x00, overflow flag 0, out_valid 0, out_data 0x00, out_overflow 0. busy is 0. in_ready is forced 0 while rst is high.
- Internal accumulator: sign, exp[2:0], mantissa[4:0] (1.ffff), plus zero flag and sticky overflow flag.
- States: ACCEPT, ALIGN, ADD, NORM, OUT.
- ACCEPT, on transfer:
  - Latch operand and in_last.
  - If the operand is zero, or overflow is already set: no arithmetic; go to OUT if last, else stay in ACCEPT.
  - If the accumulator is zero: load operand (mantissa {1,frac}); go to OUT if last, else ACCEPT.
  - Otherwise go to ALIGN.
- ALIGN:
  - Operand with the smaller exponent (ties: the incoming operand) is shifted right 1 bit per cycle, truncating; its exponent increments each cycle.
  - Ends when exponents match. d = exponent difference takes d cycles; d=0 takes 0 cycles, passing straight through to ADD in the same step.
  - If d >= MAX_ALIGN, the smaller mantissa is set to 0 in a single cycle.
- ADD (1 cycle), on 6-bit magnitudes:
  - Same signs: add.
  - Different signs: larger minus smaller; result takes the sign of the larger.
  - Equal magnitudes, opposite sign: accumulator becomes zero (+0). Skip NORM; go to OUT if last, else ACCEPT.
- NORM:
  - Carry (bit5 set): shift right 1, exp+1, 1 cycle. If exp was 7, set overflow and saturate the accumulator to {sign,111,0000}.
  - Otherwise, while bit4 == 0, shift left 1 and exp-1, 1 cycle each. If exp is 0 and bit4 is still 0, flush to zero (underflow).
  - A normalized result with exp 0 and fraction 0 also flushes to zero (that encoding means zero).
  - Exit: OUT if last, else ACCEPT.
- OUT:
  - out_valid=1, out_data = zero ? 0x00 : {sign,exp,mant[3:0]}, out_overflow = overflow flag.
  - Outputs are held stable until out_ready.
  - On transfer: accumulator zero, overflow 0, out_valid 0 next cycle; return to ACCEPT.
- Latency per nonzero addend into a nonzero accumulator: 1 (accept) + min(d, 1 if d>=MAX_ALIGN) + 1 (add) + normalization shifts. The next in_ready is the cycle after exit.
- No input is accepted in ALIGN/ADD/NORM/OUT; in_data is not sampled outside ACCEPT.
- A group containing only zeros outputs 0x00.
- Reset asserted mid-group or mid-OUT discards all state immediately with no output.

Test Plan:
- 0x30 then 0x30 (last), out_ready=1 -> out_data 0x40, out_overflow 0; second addend takes 1+0+1+1 cycles to OUT.
- 0x38 (1.5) then 0x20 (0.5, last) -> 1 ALIGN cycle, carry normalize -> 0x40.
- 0x30 then 0xB0 (last) -> exact cancellation, out_data 0x00, NORM skipped.
- 0x30 then 0x01 (last) -> 3 ALIGN cycles with truncation -> 0x32; 0x70 then 0x01 (last, d=7) -> 1 ALIGN cycle -> 0x70.
- 0x70, 0x70, 0x30 (last) -> overflow on second, third ignored -> 0x70 with out_overflow 1. Hold out_ready=0 for 5 cycles: out_data stable, in_ready 0. Next group starts clean.
- Assert rst during ALIGN of a group -> out_valid 0 and in_ready 0 during reset. After release, group 0x30, 0x30 (last) -> 0x40.

Source files
------------

// File: rtl/fp8_acc_if.sv
// fp8_acc_if: addend stream in, group sum out, both valid/ready.
interface fp8_acc_if;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_overflow;
  logic [7:0] out_data;
  modport master(output in_valid, in_data, in_last, out_ready,
                 input  in_ready, out_valid, out_data, out_overflow);
  modport slave (input  in_valid, in_data, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_overflow);
endinterface

// File: rtl/fp8_accumulator.sv
// fp8_accumulator: sums a stream of FP8 (s,e3 bias 3,f4) products per group.
module fp8_accumulator #(
  parameter int MAX_ALIGN = 5
) (
  input  logic     clk,
  input  logic     rst,
  fp8_acc_if.slave bus,
  output logic     busy
);
  typedef enum logic [2:0] {ACCEPT, ALIGN, ADD, NORM, OUT} state_t;
  localparam logic [3:0] LP_MAX = 4'(MAX_ALIGN);
  state_t     r_state, w_state, w_exit;
  logic       r_sign, w_sign, r_zero, w_zero, r_ovf, w_ovf, r_last, w_last, r_osign, w_osign;
  logic [2:0] r_exp, w_exp, r_oexp, w_oexp, w_d;
  logic [5:0] r_mant, w_mant, r_omant, w_omant, w_res;
  logic       w_acc_big, w_op_big, w_same;
  assign w_acc_big = r_exp > r_oexp;
  assign w_d       = w_acc_big ? r_exp - r_oexp : r_oexp - r_exp;
  assign w_op_big  = r_omant > r_mant;
  assign w_same    = r_sign == r_osign;
  assign w_res     = w_same ? r_mant + r_omant : w_op_big ? r_omant - r_mant : r_mant - r_omant;
  assign w_exit    = r_last ? OUT : ACCEPT;
  assign bus.in_ready     = (r_state == ACCEPT) && !rst;
  assign bus.out_valid    = r_state == OUT;
  assign bus.out_data     = (r_state == OUT && !r_zero) ? {r_sign, r_exp, r_mant[3:0]} : 8'h00;
  assign bus.out_overflow = (r_state == OUT) && r_ovf;
  assign busy             = r_state != ACCEPT;
  always_comb begin
    w_state = r_state;
    w_sign  = r_sign;
    w_exp   = r_exp;
    w_mant  = r_mant;
    w_zero  = r_zero;
    w_ovf   = r_ovf;
    w_last  = r_last;
    w_osign = r_osign;
    w_oexp  = r_oexp;
    w_omant = r_omant;
    case (r_state)
      ACCEPT: if (bus.in_valid && bus.in_ready) begin
        w_last  = bus.in_last;
        w_osign = bus.in_data[7];
        w_oexp  = bus.in_data[6:4];
        w_omant = {2'b01, bus.in_data[3:0]};
        if (bus.in_data[6:0] == 7'd0 || r_ovf) w_state = bus.in_last ? OUT : ACCEPT;
        else if (r_zero) begin
          {w_zero, w_sign, w_exp, w_mant} = {1'b0, bus.in_data[7], bus.in_data[6:4], 2'b01, bus.in_data[3:0]};
          w_state = bus.in_last ? OUT : ACCEPT;
        end else w_state = (bus.in_data[6:4] == r_exp) ? ADD : ALIGN;
      end
      ALIGN: if ({1'b0, w_d} >= LP_MAX) begin
        if (w_acc_big) {w_oexp, w_omant} = {r_exp, 6'd0};
        else {w_exp, w_mant} = {r_oexp, 6'd0};
        w_state = ADD;
      end else begin
        if (w_acc_big) {w_oexp, w_omant} = {r_oexp + 3'd1, r_omant >> 1};
        else {w_exp, w_mant} = {r_exp + 3'd1, r_mant >> 1};
        w_state = (w_d == 3'd1) ? ADD : ALIGN;
      end
      ADD: if (!w_same && r_mant == r_omant) begin
        {w_zero, w_sign, w_exp, w_mant} = {1'b1, 1'b0, 3'd0, 6'd0};
        w_state = w_exit;
      end else begin
        w_sign = w_op_big ? r_osign : r_sign;
        w_mant = w_res;
        if (w_res[5:4] == 2'b01) begin
          if (r_exp == 3'd0 && w_res[3:0] == 4'd0) {w_zero, w_sign, w_exp, w_mant} = {1'b1, 1'b0, 3'd0, 6'd0};
          w_state = w_exit;
        end else w_state = NORM;
      end
      NORM: if (r_mant[5]) begin
        if (r_exp == 3'd7) {w_ovf, w_mant} = {1'b1, 6'b010000};
        else {w_exp, w_mant} = {r_exp + 3'd1, r_mant >> 1};
        w_state = w_exit;
      end else if (r_exp == 3'd0) begin
        {w_zero, w_sign, w_exp, w_mant} = {1'b1, 1'b0, 3'd0, 6'd0};
        w_state = w_exit;
      end else begin
        {w_exp, w_mant} = {r_exp - 3'd1, r_mant << 1};
        if (w_mant[4]) begin
          if (w_exp == 3'd0 && w_mant[3:0] == 4'd0) {w_zero, w_sign, w_exp, w_mant} = {1'b1, 1'b0, 3'd0, 6'd0};
          w_state = w_exit;
        end
      end
      OUT: if (bus.out_ready) begin
        {w_zero, w_ovf, w_sign, w_exp, w_mant} = {1'b1, 1'b0, 1'b0, 3'd0, 6'd0};
        w_state = ACCEPT;
      end
      default: w_state = ACCEPT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ACCEPT;
      r_sign  <= 1'b0;
      r_exp   <= 3'd0;
      r_mant  <= 6'd0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_last  <= 1'b0;
      r_osign <= 1'b0;
      r_oexp  <= 3'd0;
      r_omant <= 6'd0;
    end else begin
      r_state <= w_state;
      r_sign  <= w_sign;
      r_exp   <= w_exp;
      r_mant  <= w_mant;
      r_zero  <= w_zero;
      r_ovf   <= w_ovf;
      r_last  <= w_last;
      r_osign <= w_osign;
      r_oexp  <= w_oexp;
      r_omant <= w_omant;
    end
endmodule

// File: tb/tb_fp8_accumulator.sv
// tb_fp8_accumulator: directed plan cases plus random groups against a value-level model.
module tb_fp8_accumulator;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int checks = 0, errors = 0;
  logic m_zero, m_sign, m_ovf;
  int m_e, m_m, nb, lat;
  logic [7:0] rb;
  fp8_acc_if u_if();
  fp8_accumulator #(.MAX_ALIGN(5)) u_dut (.clk(clk), .rst(rst), .bus(u_if), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_clear();
    m_zero = 1'b1;
    m_sign = 1'b0;
    m_ovf  = 1'b0;
    m_e    = 0;
    m_m    = 0;
  endtask
  task automatic m_to_zero();
    m_zero = 1'b1;
    m_sign = 1'b0;
    m_e    = 0;
    m_m    = 0;
  endtask
  task automatic m_add(input logic [7:0] b);
    int eb, mb, d, va, vb, s, mag, e;
    if (b[6:0] == 7'd0 || m_ovf) return;
    eb = int'(b[6:4]);
    mb = 16 + int'(b[3:0]);
    if (m_zero) begin
      m_zero = 1'b0;
      m_sign = b[7];
      m_e    = eb;
      m_m    = mb;
      return;
    end
    d = m_e > eb ? m_e - eb : eb - m_e;
    if (m_e > eb) mb = d >= 5 ? 0 : mb >> d;
    else m_m = d >= 5 ? 0 : m_m >> d;
    e  = m_e > eb ? m_e : eb;
    va = m_sign ? -m_m : m_m;
    vb = b[7] ? -mb : mb;
    s  = va + vb;
    if (s == 0) begin
      m_to_zero();
      return;
    end
    m_sign = s < 0;
    mag = s < 0 ? -s : s;
    if (mag >= 32) begin
      if (e == 7) begin
        m_ovf = 1'b1;
        mag = 16;
      end else begin
        mag = mag / 2;
        e++;
      end
    end else
      while (mag < 16) begin
        if (e == 0) begin
          m_to_zero();
          return;
        end
        mag = mag * 2;
        e--;
      end
    if (e == 0 && mag == 16) begin
      m_to_zero();
      return;
    end
    m_e = e;
    m_m = mag;
  endtask
  function automatic logic [7:0] m_out();
    return m_zero ? 8'h00 : {m_sign, m_e[2:0], m_m[3:0]};
  endfunction
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    u_if.in_data  = d;
    u_if.in_last  = l;
    u_if.in_valid = 1'b1;
    while (!u_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 32'(u_if.in_ready), 1);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    m_add(d);
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!u_if.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("out_valid_timeout", 32'(u_if.out_valid), 1);
  endtask
  task automatic take(input string tag, input logic [7:0] ed, input logic eo, input int el);
    int n;
    wait_out(n);
    if (el >= 0) chk({tag, "_lat"}, n, el);
    chk({tag, "_data"}, u_if.out_data, ed);
    chk({tag, "_ovf"}, 32'(u_if.out_overflow), 32'(eo));
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    m_clear();
    chk({tag, "_done"}, 32'(u_if.out_valid), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.in_data = 8'h00;
    u_if.in_last = 1'b0;
    u_if.out_ready = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(u_if.in_ready), 0);
    chk("rst_out_valid", 32'(u_if.out_valid), 0);
    chk("rst_out_data", u_if.out_data, 0);
    chk("rst_out_ovf", 32'(u_if.out_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(u_if.in_ready), 1);
    send(8'h30, 1'b0); send(8'h30, 1'b1); take("same_exp", 8'h40, 1'b0, 2);
    send(8'h38, 1'b0); send(8'h20, 1'b1); take("carry", 8'h40, 1'b0, 3);
    send(8'h30, 1'b0); send(8'hB0, 1'b1); take("cancel", 8'h00, 1'b0, 1);
    send(8'h30, 1'b0); send(8'h01, 1'b1); take("trunc", 8'h32, 1'b0, 4);
    send(8'h70, 1'b0); send(8'h01, 1'b1); take("far", 8'h70, 1'b0, 2);
    send(8'h70, 1'b0); send(8'h70, 1'b0); send(8'h30, 1'b1);
    wait_out(lat);
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", u_if.out_data, 8'h70);
      chk("hold_in_ready", 32'(u_if.in_ready), 0);
    end
    take("ovf", 8'h70, 1'b1, -1);
    send(8'h30, 1'b0); send(8'h30, 1'b1); take("clean", 8'h40, 1'b0, 2);
    send(8'h00, 1'b0); send(8'h80, 1'b1); take("zeros", 8'h00, 1'b0, -1);
    send(8'h30, 1'b0); send(8'h01, 1'b1);
    chk("align_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(u_if.in_ready), 0);
    chk("mid_rst_out_valid", 32'(u_if.out_valid), 0);
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    m_clear();
    @(negedge clk);
    send(8'h30, 1'b0); send(8'h30, 1'b1); take("post_rst", 8'h40, 1'b0, 2);
    for (int g = 0; g < 40; g++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 5) == 0) rb[6:0] = 7'd0;
        send(rb, i == nb - 1);
      end
      take("rnd", m_out(), m_ovf, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
